// File: rtl/mult_fu.sv
// rtl/mult_fu.sv - pipelined integer multiply functional unit with branch-mask tracking and CDB hold register
package mult_fu_pkg;
  typedef logic [3:0] BR_MASK;
  typedef enum logic [1:0] {NOP = 2'd0, SQUASH = 2'd1, CLEAR = 2'd2} BR_TASK;

  typedef struct packed {
    logic valid;
  } DECODED_VALS;

  typedef struct packed {
    logic [5:0] reg_idx;
  } PREG;

  typedef struct packed {
    DECODED_VALS decoded_vals;
    PREG         t;
    BR_MASK      b_mask;
  } RS_PACKET;

  typedef struct packed {
    logic       valid;
    logic [5:0] reg_idx;
  } CDB_PACKET;
endpackage

module mult_fu
  import mult_fu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  RS_PACKET        issue_in,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [1:0]      func,
  input  BR_MASK          br_id,
  input  BR_TASK          br_task,
  input  logic            cdb_gnt,
  output logic            busy,
  output logic            cdb_req,
  output CDB_PACKET       cdb_out,
  output logic [XLEN-1:0] result_val
);

  localparam int W    = 2 * XLEN;
  localparam int BITS = W / STAGES;

  typedef struct packed {
    logic         valid;
    PREG          tag;
    BR_MASK       mask;
    logic [1:0]   func;
    logic [W-1:0] mcand;
    logic [W-1:0] mplier;
    logic [W-1:0] sum;
  } stage_t;

  function automatic stage_t br_apply(input stage_t s, input BR_TASK t, input BR_MASK id);
    stage_t r;
    r = s;
    if (s.valid && (s.mask & id) != '0) begin
      if (t == SQUASH) r.valid = 1'b0;
      else if (t == CLEAR) r.mask = s.mask ^ id;
    end
    return r;
  endfunction

  // One slice of shift-and-add: consume BITS multiplier bits per stage.
  function automatic stage_t step(input stage_t s);
    stage_t       r;
    logic [W-1:0] chunk;
    chunk            = '0;
    chunk[BITS-1:0]  = s.mplier[BITS-1:0];
    r                = s;
    r.sum            = s.sum + s.mcand * chunk;
    r.mcand          = s.mcand << BITS;
    r.mplier         = s.mplier >> BITS;
    return r;
  endfunction

  // stg[STAGES-1] is the output register; its sum holds the full product.
  stage_t stg [STAGES];
  stage_t nxt [STAGES];
  stage_t issue_rec;
  stage_t out_reg;
  logic   stall;
  logic   squash_out;

  assign out_reg = stg[STAGES-1];
  assign stall   = out_reg.valid & ~cdb_gnt;
  assign busy    = stall;

  always_comb begin
    issue_rec        = '0;
    issue_rec.valid  = issue_in.decoded_vals.valid & ~stall;
    issue_rec.tag    = issue_in.t;
    issue_rec.mask   = issue_in.b_mask;
    issue_rec.func   = func;
    issue_rec.mcand  = (func == 2'd3) ? {{XLEN{1'b0}}, rs1_val}
                                      : {{XLEN{rs1_val[XLEN-1]}}, rs1_val};
    issue_rec.mplier = func[1] ? {{XLEN{1'b0}}, rs2_val}
                               : {{XLEN{rs2_val[XLEN-1]}}, rs2_val};
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt[k] = (k == 0) ? step(issue_rec) : step(stg[(k == 0) ? 0 : k-1]);
    end
  end

  // Branch resolution still applies to held entries while stalled.
  always_ff @(posedge clock) begin
    for (int k = 0; k < STAGES; k++) begin
      if (reset)      stg[k] <= '0;
      else if (stall) stg[k] <= br_apply(stg[k], br_task, br_id);
      else            stg[k] <= br_apply(nxt[k], br_task, br_id);
    end
  end

  assign squash_out      = (br_task == SQUASH) && ((out_reg.mask & br_id) != '0);
  assign cdb_req         = out_reg.valid & ~squash_out;
  assign cdb_out.valid   = cdb_req & cdb_gnt;
  assign cdb_out.reg_idx = out_reg.tag.reg_idx;
  assign result_val      = (out_reg.func == 2'd0) ? out_reg.sum[XLEN-1:0] : out_reg.sum[W-1:XLEN];

endmodule

// File: tb/tb_mult_fu.sv
// tb/tb_mult_fu.sv - directed self-checking bench for mult_fu
module tb_mult_fu;
  import mult_fu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  RS_PACKET    issue_in;
  logic [31:0] rs1_val, rs2_val;
  logic [1:0]  func;
  BR_MASK      br_id;
  BR_TASK      br_task;
  logic        cdb_gnt;
  logic        busy, cdb_req;
  CDB_PACKET   cdb_out;
  logic [31:0] result_val;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  mult_fu #(.XLEN(32), .STAGES(4)) dut (
    .clock(clock), .reset(reset), .issue_in(issue_in), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .func(func), .br_id(br_id), .br_task(br_task), .cdb_gnt(cdb_gnt), .busy(busy),
    .cdb_req(cdb_req), .cdb_out(cdb_out), .result_val(result_val)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    issue_in = '0;
    rs1_val  = '0;
    rs2_val  = '0;
    func     = 2'd0;
    br_id    = '0;
    br_task  = NOP;
  endtask

  task automatic issue(input int tag, input logic [3:0] mask, input logic [1:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    issue_in.decoded_vals.valid = 1'b1;
    issue_in.t.reg_idx          = tag[5:0];
    issue_in.b_mask             = mask;
    func                        = f;
    rs1_val                     = a;
    rs2_val                     = b;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    idle_in();
  endtask

  task automatic expect_bc(input string name, input int tag, input logic [31:0] val);
    chk({name, ".valid"}, {31'd0, cdb_out.valid}, 32'd1);
    chk({name, ".tag"}, {26'd0, cdb_out.reg_idx}, tag);
    chk({name, ".result"}, result_val, val);
  endtask

  task automatic expect_none(input string name);
    chk({name, ".valid"}, {31'd0, cdb_out.valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{2'd0, 32'd7,        32'd6,        32'd42};
    vecs[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[2] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3] = '{2'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
    vecs[4] = '{2'd0, 32'h80000000, 32'd2,        32'h00000000};
    vecs[5] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[6] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[7] = '{2'd3, 32'h12345678, 32'h00000010, 32'h00000001};
    vecs[8] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[9] = '{2'd0, 32'h12345678, 32'h00000010, 32'h23456780};

    idle_in();
    reset   = 1'b1;
    cdb_gnt = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.cdb_req", {31'd0, cdb_req}, 32'd0);
    chk("reset.cdb_out", {25'd0, cdb_out}, 32'd0);
    chk("reset.result", result_val, 32'd0);
    reset = 1'b0;
    next_cycle();

    // Table: one issue each, broadcast expected exactly four cycles later.
    for (int i = 0; i < 10; i++) begin
      issue(12 + i, 4'b0000, vecs[i].f, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("vec%0d.busy", i), {31'd0, busy}, 32'd0);
      next_cycle();
      for (int c = 1; c < 4; c++) begin
        #1;
        expect_none($sformatf("vec%0d.c%0d", i, c));
        next_cycle();
      end
      #1;
      expect_bc($sformatf("vec%0d", i), 12 + i, vecs[i].exp);
      next_cycle();
    end

    // Backpressure: four back-to-back issues, grant withheld cycles 4-6.
    for (int c = 0; c < 12; c++) begin
      if (c < 4) issue(c + 1, 4'b0000, 2'd0, c + 1, 32'd100);
      else if (c < 7) issue(9, 4'b0000, 2'd0, 32'd5, 32'd5);
      cdb_gnt = !(c >= 4 && c <= 6);
      #1;
      if (c < 4) expect_none($sformatf("bp.c%0d", c));
      if (c >= 4 && c <= 6) begin
        chk($sformatf("bp.busy.c%0d", c), {31'd0, busy}, 32'd1);
        chk($sformatf("bp.req.c%0d", c), {31'd0, cdb_req}, 32'd1);
        expect_none($sformatf("bp.c%0d", c));
      end
      if (c >= 7 && c <= 10) begin
        expect_bc($sformatf("bp.c%0d", c), c - 6, (c - 6) * 100);
        chk($sformatf("bp.busy.c%0d", c), {31'd0, busy}, 32'd0);
      end
      if (c == 11) expect_none("bp.c11");
      next_cycle();
    end
    cdb_gnt = 1'b1;
    repeat (4) next_cycle();

    // Squash: B squashed mid-pipe, A survives.
    for (int c = 0; c < 6; c++) begin
      if (c == 0) issue(5, 4'b0001, 2'd0, 32'd3, 32'd4);
      if (c == 1) issue(6, 4'b0010, 2'd0, 32'd5, 32'd5);
      if (c == 3) begin br_task = SQUASH; br_id = 4'b0010; end
      #1;
      if (c == 3) expect_none("sq.c3");
      if (c == 4) expect_bc("sq.c4", 5, 32'd12);
      if (c == 5) expect_none("sq.c5");
      next_cycle();
    end
    repeat (3) next_cycle();

    // Squash of the held output register in the same cycle as its grant.
    for (int c = 0; c < 9; c++) begin
      if (c == 0) issue(7, 4'b0100, 2'd0, 32'd2, 32'd2);
      if (c == 2) issue(13, 4'b0001, 2'd0, 32'd9, 32'd9);
      cdb_gnt = (c != 4);
      if (c == 5) begin br_task = SQUASH; br_id = 4'b0100; end
      #1;
      if (c == 4) begin
        chk("sg.req.c4", {31'd0, cdb_req}, 32'd1);
        chk("sg.busy.c4", {31'd0, busy}, 32'd1);
      end
      if (c == 5) begin
        chk("sg.req.c5", {31'd0, cdb_req}, 32'd0);
        expect_none("sg.c5");
      end
      if (c == 6) chk("sg.req.c6", {31'd0, cdb_req}, 32'd0);
      if (c == 7) expect_bc("sg.c7", 13, 32'd81);
      if (c == 8) expect_none("sg.c8");
      next_cycle();
    end
    cdb_gnt = 1'b1;
    repeat (3) next_cycle();

    // CLEAR removes the branch from D's mask, so the later SQUASH misses it.
    for (int c = 0; c < 6; c++) begin
      if (c == 0) issue(8, 4'b1000, 2'd0, 32'd11, 32'd3);
      if (c == 1) begin br_task = CLEAR;  br_id = 4'b1000; end
      if (c == 2) begin br_task = SQUASH; br_id = 4'b1000; end
      #1;
      if (c == 3) expect_none("clr.c3");
      if (c == 4) expect_bc("clr.c4", 8, 32'd33);
      if (c == 5) expect_none("clr.c5");
      next_cycle();
    end
    repeat (3) next_cycle();

    // Reset with three entries in flight.
    for (int c = 0; c < 9; c++) begin
      if (c < 3) issue(10 + c, 4'b0000, 2'd0, 32'd2, c + 1);
      reset = (c == 2);
      #1;
      if (c >= 3) begin
        chk($sformatf("rst.req.c%0d", c), {31'd0, cdb_req}, 32'd0);
        chk($sformatf("rst.busy.c%0d", c), {31'd0, busy}, 32'd0);
        expect_none($sformatf("rst.c%0d", c));
      end
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_fu.md
# mult_fu

Pipelined integer multiply functional unit that consumes `RS_PACKET` issues from the reservation station's mult port and returns completed results on the CDB. It drives the RS's `fu_mult_busy` bit, tracks branch masks so in-flight work obeys SQUASH/CLEAR, and holds a finished result in an output register until the CDB arbiter grants it.

## Interface

**Parameters**
- `XLEN`, default 32: operand width.
- `STAGES`, default 4: multiply pipeline depth. Must divide `2*XLEN`.

**Ports**
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `issue_in` in `RS_PACKET`: issued instruction. Valid iff `issue_in.decoded_vals.valid`.
- `rs1_val` in `XLEN`: operand A, aligned with `issue_in`.
- `rs2_val` in `XLEN`: operand B, aligned with `issue_in`.
- `func` in 2: operation select. 0 = MUL, 1 = MULH, 2 = MULHSU, 3 = MULHU.
- `br_id` in `BR_MASK`: one-hot branch being resolved.
- `br_task` in `BR_TASK`: SQUASH / CLEAR / other (other means no action).
- `cdb_gnt` in 1: CDB arbiter grant for this FU.
- `busy` out 1: to RS `fu_mult_busy`. Issue is not accepted this cycle.
- `cdb_req` out 1: a completed, unsquashed result is held.
- `cdb_out` out `CDB_PACKET`: `valid = cdb_req & cdb_gnt`; `reg_idx` is the destination tag (`issue_in.t.reg_idx`).
- `result_val` out `XLEN`: result data, valid with `cdb_out.valid`.

## Operation

- **Issue acceptance:** accepted when `issue_in` is valid and `busy=0`. The RS never issues while `busy=1`; if it does, the FU ignores the issue.
- **Operand preparation at acceptance:** operands are extended to `2*XLEN`.
  - A is sign-extended for MUL, MULH and MULHSU; zero-extended for MULHU.
  - B is sign-extended for MUL and MULH; zero-extended otherwise.
- **Stage state:** each stage register holds valid, tag, `b_mask`, func, multiplicand, remaining multiplier bits, and the partial sum (`2*XLEN`).
- **Per-stage work:** each stage adds partial products for `2*XLEN/STAGES` multiplier bits, shifts, and passes the result on. All arithmetic is modulo `2^(2*XLEN)`.
- **Final stage:** writes the output register. `result_val` is:
  - `product[XLEN-1:0]` for MUL;
  - `product[2*XLEN-1:XLEN]` for the other three functions.
- **Stall:** `stall = out_valid & ~cdb_gnt`.
  - While stalled, all stages and the output register hold.
  - `busy = stall`, combinational.
- **Grant:** when `cdb_gnt=1` and `out_valid=1`, the output register loads from the last stage in the same edge. Full throughput is preserved; bubbles propagate normally.
- **SQUASH** (`br_task==SQUASH`), applied to every stage, the output register and the incoming issue:
  - An entry with `(b_mask & br_id) != 0` is invalidated at the next edge.
  - `cdb_req` is masked combinationally in the squash cycle, so a squashed output is never broadcast, even with `cdb_gnt=1`.
- **CLEAR** (`br_task==CLEAR`): `b_mask ^= br_id` on every valid entry whose mask contains `br_id`, including the incoming issue.
- **Ordering:** results retire strictly in issue order.

## Timing

- **Reset:** all valid bits are 0, so `busy=0`, `cdb_req=0`, `cdb_out=0` and `result_val=0`.
  - Reset mid-operation discards every in-flight entry at the next edge.
- **Latency:** an issue accepted in cycle c gives `cdb_req=1` in cycle c+`STAGES`, with no stall.
  - With `cdb_gnt` held high, the CDB broadcast occurs in cycle c+`STAGES`.
- **Throughput:** one issue per cycle while unstalled.
- **Capacity:** at most `STAGES` entries in flight (stages plus output register).
- **`busy` path:** `busy` depends combinationally on `cdb_gnt` in the same cycle. The RS psel consumes it combinationally.
- **Squash vs. grant:** squash in the same cycle as a grant of the output register means no broadcast. The output register still reloads from the last stage that edge (the squash check also applies to the entry loaded).
- **Squash vs. CLEAR:** the two are mutually exclusive per cycle, by `br_task` encoding.

## Test plan

- **Basic MUL:** issue MUL 7×6, tag 12, at cycle 0, `cdb_gnt` tied high → `cdb_out.valid=1`, `reg_idx=12`, `result_val=42` at cycle 4; idle before that.
- **Signedness:** with `cdb_gnt` high:
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000;
  - MULHU same operands → 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF;
  - MUL 0x80000000×2 → 0x00000000.
- **Backpressure:** four back-to-back issues (tags 1–4), `cdb_gnt=0` for cycles 4–6 → `busy=1` in cycles 4–6, no new issue accepted; tags 1, 2, 3, 4 broadcast in cycles 7, 8, 9, 10 with correct values.
- **Squash:** issue A (mask 0001) at cycle 0 and B (mask 0010) at cycle 1; SQUASH `br_id=0010` at cycle 3 → only A broadcast, at cycle 4; no broadcast at cycle 5.
- **Squash at grant:** output register holds C (mask 0100), SQUASH `br_id=0100` with `cdb_gnt=1` in the same cycle → `cdb_out.valid=0`.
- **CLEAR, then reset:**
  - Issue D (mask 1000); CLEAR 1000 at cycle 1; SQUASH 1000 at cycle 2 → D still broadcast at cycle 4.
  - Assert `reset` at cycle 2 with three entries in flight → no broadcasts afterwards; `busy=0`, `cdb_req=0`.
